// File: rtl/pipeline_control.sv
// Hazard, stall and flush control for a five-stage pipeline, with a halt drain sequence.
// Define PIPE_PERF_CNT_EN to add the cycle_cnt / stall_cnt performance counters.
module pipeline_control (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_mem,
  input  logic        dWEN_mem,
  input  logic        dREN_ex,
  input  logic [4:0]  wsel_ex,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        rt_used_id,
  input  logic        branch_taken_mem,
  input  logic        jump_id,
  input  logic        halt_mem,
  output logic        pc_enable,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        idex_enable,
  output logic        idex_flush,
  output logic        exmem_enable,
  output logic        exmem_flush,
  output logic        memwb_enable,
  output logic        memwb_flush,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        halted
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DWAIT  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0] state_q, state_d;
  logic       memok, load_use;

  assign memok    = !(dREN_mem || dWEN_mem) || dhit;
  assign load_use = dREN_ex && (wsel_ex != 5'd0) &&
                    ((wsel_ex == rs_id) || (rt_used_id && (wsel_ex == rt_id)));

  always_comb begin
    state_d      = state_q;
    pc_enable    = 1'b0;
    ifid_enable  = 1'b0;
    idex_enable  = 1'b0;
    exmem_enable = 1'b0;
    memwb_enable = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    halted       = 1'b0;

    if (RST) begin
      state_d     = RUN;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN, DWAIT: begin
          if (memok) begin
            state_d      = RUN;
            pc_enable    = 1'b1;
            ifid_enable  = 1'b1;
            idex_enable  = 1'b1;
            exmem_enable = 1'b1;
            memwb_enable = 1'b1;
            if (!ihit) begin
              pc_enable  = 1'b0;
              ifid_flush = 1'b1;
            end
            if (jump_id) ifid_flush = 1'b1;
            // A load-use stall must keep IF/ID intact, so it cancels any fetch bubble.
            if (load_use) begin
              pc_enable   = 1'b0;
              ifid_enable = 1'b0;
              ifid_flush  = 1'b0;
              idex_flush  = 1'b1;
            end
            // A taken branch squashes the younger stages, so the stall is moot.
            if (branch_taken_mem) begin
              pc_enable   = 1'b1;
              ifid_enable = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
            end
            if (halt_mem) begin
              pc_enable   = 1'b0;
              exmem_flush = 1'b1;
              state_d     = DRAIN;
            end
          end else begin
            state_d = DWAIT;
          end
        end
        DRAIN: begin
          memwb_enable = 1'b1;
          state_d      = HALTED;
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (state_q != HALTED) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (!pc_enable) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control; outputs are checked as a packed vector.
module tb_pipeline_control;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
  logic [4:0] wsel_ex, rs_id, rt_id;
  logic       rt_used_id, branch_taken_mem, jump_id, halt_mem;
  logic       pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic       exmem_enable, exmem_flush, memwb_enable, memwb_flush, halted;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_control dut (
    .CLK              (CLK),
    .RST              (RST),
    .ihit             (ihit),
    .dhit             (dhit),
    .dREN_mem         (dREN_mem),
    .dWEN_mem         (dWEN_mem),
    .dREN_ex          (dREN_ex),
    .wsel_ex          (wsel_ex),
    .rs_id            (rs_id),
    .rt_id            (rt_id),
    .rt_used_id       (rt_used_id),
    .branch_taken_mem (branch_taken_mem),
    .jump_id          (jump_id),
    .halt_mem         (halt_mem),
    .pc_enable        (pc_enable),
    .ifid_enable      (ifid_enable),
    .ifid_flush       (ifid_flush),
    .idex_enable      (idex_enable),
    .idex_flush       (idex_flush),
    .exmem_enable     (exmem_enable),
    .exmem_flush      (exmem_flush),
    .memwb_enable     (memwb_enable),
    .memwb_flush      (memwb_flush),
`ifdef PIPE_PERF_CNT_EN
    .cycle_cnt        (cycle_cnt),
    .stall_cnt        (stall_cnt),
`endif
    .halted           (halted)
  );

  always #5 CLK = ~CLK;

  // Order: pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, halted
  localparam logic [9:0] V_RESET  = 10'b00000_1111_0;
  localparam logic [9:0] V_RUN    = 10'b11111_0000_0;
  localparam logic [9:0] V_STALL  = 10'b00000_0000_0;
  localparam logic [9:0] V_LDUSE  = 10'b00111_0100_0;
  localparam logic [9:0] V_BRANCH = 10'b11111_1110_0;
  localparam logic [9:0] V_JUMP   = 10'b11111_1000_0;
  localparam logic [9:0] V_BUBBLE = 10'b01111_1000_0;
  localparam logic [9:0] V_HALT   = 10'b01111_0010_0;
  localparam logic [9:0] V_DRAIN  = 10'b00001_0000_0;
  localparam logic [9:0] V_HALTED = 10'b00000_0000_1;

  function automatic logic [9:0] obs();
    return {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] o;
    #1;
    o = obs();
    n_chk++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [31:0 ] o, input logic [31:0] exp);
    n_chk++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
    end
  endtask
`endif

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0; dREN_ex = 1'b0;
    wsel_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; rt_used_id = 1'b0;
    branch_taken_mem = 1'b0; jump_id = 1'b0; halt_mem = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    chk("reset", V_RESET);
`ifdef PIPE_PERF_CNT_EN
    chk_cnt("cycle_cnt_reset", cycle_cnt, 32'd0);
`endif
    step();
    RST = 1'b0;
    chk("run_after_reset", V_RUN);
    step();

    // Load-use via rs, then clears to normal advance
    dREN_ex = 1'b1; wsel_ex = 5'd5; rs_id = 5'd5;
    chk("loaduse_rs", V_LDUSE);
    step();
    idle_inputs();
    chk("loaduse_release", V_RUN);
    step();

    dREN_ex = 1'b1; wsel_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7; rt_used_id = 1'b1;
    chk("loaduse_rt", V_LDUSE);
    rt_used_id = 1'b0;
    chk("rt_unused_no_stall", V_RUN);
    wsel_ex = 5'd0; rs_id = 5'd0;
    chk("r0_no_stall", V_RUN);
    step();
    idle_inputs();

    // Data miss: three wait cycles then hit
    dREN_mem = 1'b1;
    chk("dmiss_c1", V_STALL);
    step();
    chk("dwait_c2", V_STALL);
    step();
    chk("dwait_c3", V_STALL);
    step();
    dhit = 1'b1;
    chk("dwait_hit", V_RUN);
    step();
    idle_inputs();
    chk("run_after_dwait", V_RUN);

    dWEN_mem = 1'b1; dhit = 1'b1;
    chk("store_hit", V_RUN);
    idle_inputs();

    dREN_ex = 1'b1; wsel_ex = 5'd9; rs_id = 5'd9; branch_taken_mem = 1'b1;
    chk("branch_over_loaduse", V_BRANCH);
    step();
    idle_inputs();
    chk("no_stall_after_branch", V_RUN);

    jump_id = 1'b1;
    chk("jump", V_JUMP);
    dREN_ex = 1'b1; wsel_ex = 5'd4; rs_id = 5'd4;
    chk("jump_with_loaduse", V_LDUSE);
    idle_inputs();
    ihit = 1'b0;
    chk("ihit_bubble", V_BUBBLE);
    idle_inputs();
    step();

    // Reset in the middle of DWAIT
    dREN_mem = 1'b1;
    step();
    chk("dwait_before_rst", V_STALL);
    RST = 1'b1;
    chk("rst_in_dwait", V_RESET);
    step();
    chk("rst_held", V_RESET);
`ifdef PIPE_PERF_CNT_EN
    chk_cnt("cycle_cnt_after_rst", cycle_cnt, 32'd0);
`endif
    RST = 1'b0;
    idle_inputs();
    chk("run_after_rst", V_RUN);
    step();
    step();
`ifdef PIPE_PERF_CNT_EN
    chk_cnt("cycle_cnt_two", cycle_cnt, 32'd2);
    chk_cnt("stall_cnt_zero", stall_cnt, 32'd0);
`endif

    halt_mem = 1'b1;
    chk("halt", V_HALT);
    step();
    idle_inputs();
    chk("drain", V_DRAIN);
    step();
    for (int i = 0; i < 12; i++) begin
      dREN_mem = i[0]; dhit = i[1]; halt_mem = i[2];
      chk("halted_hold", V_HALTED);
      step();
    end
`ifdef PIPE_PERF_CNT_EN
    chk_cnt("cycle_cnt_frozen", cycle_cnt, 32'd4);
    chk_cnt("stall_cnt_halt", stall_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
